// File: rtl/stream_demux_1to4_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: lane state encoding,
// default widths and the 4-to-1 mux used for the ready lookup.
package stream_demux_1to4_pkg;

    localparam int unsigned DEF_MUX_SIZE = 32;
    localparam int unsigned DEF_CNT_SIZE = 8;
    localparam int unsigned NUM_LANES    = 4;
    localparam int unsigned SEL_W        = 2;

    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

    // 4-to-1 single-bit mux
    function automatic logic mux4_1(input logic [NUM_LANES-1:0] d, input logic [SEL_W-1:0] s);
        return d[s];
    endfunction

endpackage

// File: rtl/stream_demux_1to4_lane.sv
// One output lane: EMPTY/FULL handshake FSM, payload register and
// delivered-payload counter.
module demux_lane
    import stream_demux_1to4_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_MUX_SIZE,
    parameter int unsigned CNT_W  = DEF_CNT_SIZE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              lane_rdy_c_o
);

    lane_state_e       r_state;
    lane_state_e       w_state_nxt;
    logic              w_deliver;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= LANE_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new load always keeps the lane FULL, even while the old payload leaves
    always_comb begin
        w_state_nxt = r_state;
        w_deliver   = 1'b0;
        case (r_state)
            LANE_EMPTY: begin
                if (load_i) begin
                    w_state_nxt = LANE_FULL;
                end
            end
            LANE_FULL: begin
                w_deliver = ready_i;
                if (!load_i && ready_i) begin
                    w_state_nxt = LANE_EMPTY;
                end
            end
            default: w_state_nxt = LANE_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= '0;
        end else if (load_i) begin
            r_data <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (w_deliver) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign valid_o      = (r_state == LANE_FULL);
    assign data_o       = r_data;
    assign count_o      = r_count;
    assign lane_rdy_c_o = (r_state == LANE_EMPTY) || ready_i;

endmodule

// File: rtl/stream_demux_1to4.sv
// 1-to-4 valid/ready stream demultiplexer: routes each accepted payload to the
// lane picked by sel_i, with one register stage per lane.
module stream_demux_1to4
    import stream_demux_1to4_pkg::*;
#(
    parameter int unsigned mux_size = DEF_MUX_SIZE,
    parameter int unsigned cnt_size = DEF_CNT_SIZE
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [mux_size-1:0] data_i,
    input  logic [SEL_W-1:0]    sel_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [mux_size-1:0] data_0_o,
    output logic [mux_size-1:0] data_1_o,
    output logic [mux_size-1:0] data_2_o,
    output logic [mux_size-1:0] data_3_o,
    output logic                valid_0_o,
    output logic                valid_1_o,
    output logic                valid_2_o,
    output logic                valid_3_o,
    input  logic                ready_0_i,
    input  logic                ready_1_i,
    input  logic                ready_2_i,
    input  logic                ready_3_i,
    output logic [cnt_size-1:0] count_0_o,
    output logic [cnt_size-1:0] count_1_o,
    output logic [cnt_size-1:0] count_2_o,
    output logic [cnt_size-1:0] count_3_o
);

    logic [NUM_LANES-1:0] w_ready_in;
    logic [NUM_LANES-1:0] w_lane_rdy;
    logic [NUM_LANES-1:0] w_load;
    logic [NUM_LANES-1:0] w_valid;
    logic [mux_size-1:0]  w_data  [NUM_LANES];
    logic [cnt_size-1:0]  w_count [NUM_LANES];
    logic                 w_in_xfer;

    assign w_ready_in = {ready_3_i, ready_2_i, ready_1_i, ready_0_i};

    // Acceptance depends only on the addressed lane, never on valid_i
    assign ready_o   = mux4_1(w_lane_rdy, sel_i);
    assign w_in_xfer = valid_i && ready_o;
    assign w_load    = w_in_xfer ? NUM_LANES'(4'b0001 << sel_i) : '0;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux_lane #(
            .DATA_W (mux_size),
            .CNT_W  (cnt_size)
        ) u_lane (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .load_i       (w_load[g]),
            .data_i       (data_i),
            .ready_i      (w_ready_in[g]),
            .valid_o      (w_valid[g]),
            .data_o       (w_data[g]),
            .count_o      (w_count[g]),
            .lane_rdy_c_o (w_lane_rdy[g])
        );
    end

    assign data_0_o  = w_data[0];
    assign data_1_o  = w_data[1];
    assign data_2_o  = w_data[2];
    assign data_3_o  = w_data[3];
    assign valid_0_o = w_valid[0];
    assign valid_1_o = w_valid[1];
    assign valid_2_o = w_valid[2];
    assign valid_3_o = w_valid[3];
    assign count_0_o = w_count[0];
    assign count_1_o = w_count[1];
    assign count_2_o = w_count[2];
    assign count_3_o = w_count[3];

endmodule
